// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencer. The instruction memory
// and the branch-target unit use the same address width and start address.
//   pc_state_e    : sequencer FSM state (2 bits)
//   PC_D          : default PC / instruction-address width
//   PC_START_ADDR : default PC loaded on each program start
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int PC_D = 12;
    localparam logic [PC_D-1:0] PC_START_ADDR = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pc_state_e;

endpackage

// File: rtl/pc_next.sv
// -----------------------------------------------------------------------------
// pc_next
// Combinational next-PC adder.
//   pc_i           : current program counter
//   branch_en_i    : select branch (pc + offset) instead of sequential (pc + 1)
//   target_i       : signed two's-complement branch offset, D bits
//   next_pc_o      : candidate next PC, modulo 2^D
//   seq_overflow_o : sequential increment attempted from 2^D-1
// -----------------------------------------------------------------------------
module pc_next
    import pc_seq_pkg::*;
#(
    parameter int D = PC_D
) (
    input  logic [D-1:0] pc_i,
    input  logic         branch_en_i,
    input  logic [D-1:0] target_i,
    output logic [D-1:0] next_pc_o,
    output logic         seq_overflow_o
);

    // Offset and PC share the same width, so a plain D-bit add equals adding
    // the sign-extended offset modulo 2^D. Branch wrap is legal, not a fault.
    always_comb begin
        if (branch_en_i) begin
            next_pc_o = pc_i + target_i;
        end else begin
            next_pc_o = pc_i + {{(D-1){1'b0}}, 1'b1};
        end
    end

    assign seq_overflow_o = !branch_en_i && (pc_i == {D{1'b1}});

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the program counter and sequences instruction fetch.
//   Clk        : system clock, rising edge
//   Reset      : asynchronous active-high reset, clears all state
//   Start      : program start request (sampled in IDLE / DONE)
//   Stall      : hold PC this cycle
//   BranchEn   : branch taken for instruction at current PC
//   Target     : signed PC offset for the branch
//   Halt       : instruction at current PC is the halt instruction
//   ProgAddr   : current PC to instruction memory
//   Running    : high in RUN and DRAIN
//   Done       : high in DONE
//   Fault      : sequential fetch ran past address 2^D-1
//   InstrCount : saturating retired-instruction count for the current run
// All outputs come from registers or a decode of the state register.
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              D          = PC_D,
    parameter int              CNT_W      = 16,
    parameter logic [D-1:0]    START_ADDR = PC_START_ADDR
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic [D-1:0]     Target,
    input  logic             Halt,
    output logic [D-1:0]     ProgAddr,
    output logic             Running,
    output logic             Done,
    output logic             Fault,
    output logic [CNT_W-1:0] InstrCount
);

    pc_state_e        state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    logic [D-1:0]     next_pc;
    logic             seq_overflow;
    logic [CNT_W-1:0] cnt_inc;

    pc_next #(
        .D (D)
    ) u_pc_next (
        .pc_i           (pc_q),
        .branch_en_i    (BranchEn),
        .target_i       (Target),
        .next_pc_o      (next_pc),
        .seq_overflow_o (seq_overflow)
    );

    // Retired count sticks at all-ones rather than wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                              : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end

            ST_RUN: begin
                // Stall freezes everything; Halt outranks a taken branch.
                if (!Stall) begin
                    cnt_d = cnt_inc;
                    if (Halt) begin
                        state_d = ST_DRAIN;
                    end else if (seq_overflow) begin
                        // Ran off the top of memory: keep PC at 2^D-1.
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end

            // Single cycle for the halt instruction's writeback.
            ST_DRAIN: state_d = ST_DONE;

            default: state_d = ST_IDLE;
        endcase
    end

    assign ProgAddr   = pc_q;
    assign Running    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign Done       = (state_q == ST_DONE);
    assign Fault      = fault_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Two sequencers share one stimulus stream: one starting at 0 with a 16-bit
// counter, one starting at 0xFFE with a 3-bit counter (fast saturation and
// top-of-memory fault). A reference model per instance pushes the expected
// outputs each cycle; a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int D = 12;

    logic          Clk = 1'b0;
    logic          Reset, Start, Stall, BranchEn, Halt;
    logic [D-1:0]  Target;

    logic [D-1:0]  pa0, pa1;
    logic          run0, run1, done0, done1, flt0, flt1;
    logic [15:0]   cnt0;
    logic [2:0]    cnt1;

    typedef struct packed {
        logic [11:0] pc;
        logic        running;
        logic        done;
        logic        fault;
        logic [15:0] cnt;
    } obs_t;

    obs_t q0[$];
    obs_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: phase 0=idle 1=run 2=drain 3=done.
    int m_phase[2];
    int m_pc[2];
    int m_cnt[2];
    bit m_fault[2];
    int m_start[2] = '{0, 'hFFE};
    int m_max[2]   = '{65535, 7};

    pc_sequencer #(.D(D), .CNT_W(16), .START_ADDR(12'h000)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .Target(Target), .Halt(Halt),
        .ProgAddr(pa0), .Running(run0), .Done(done0), .Fault(flt0),
        .InstrCount(cnt0)
    );

    pc_sequencer #(.D(D), .CNT_W(3), .START_ADDR(12'hFFE)) dut_hi (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .Target(Target), .Halt(Halt),
        .ProgAddr(pa1), .Running(run1), .Done(done1), .Fault(flt1),
        .InstrCount(cnt1)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset(input int k);
        m_phase[k] = 0;
        m_pc[k]    = 0;
        m_cnt[k]   = 0;
        m_fault[k] = 0;
    endtask

    task automatic retire(input int k);
        if (m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 1;
    endtask

    task automatic model_step(input int k);
        int off;
        if (Reset) begin
            model_reset(k);
        end else if (m_phase[k] == 0 || m_phase[k] == 3) begin
            if (Start) begin
                m_phase[k] = 1;
                m_pc[k]    = m_start[k];
                m_cnt[k]   = 0;
                m_fault[k] = 0;
            end
        end else if (m_phase[k] == 2) begin
            m_phase[k] = 3;
        end else if (!Stall) begin
            retire(k);
            if (Halt) begin
                m_phase[k] = 2;
            end else if (BranchEn) begin
                off = int'(Target);
                if (off >= 2048) off = off - 4096;
                m_pc[k] = (m_pc[k] + off + 4096) % 4096;
            end else if (m_pc[k] == 4095) begin
                m_fault[k] = 1;
                m_phase[k] = 3;
            end else begin
                m_pc[k] = m_pc[k] + 1;
            end
        end
    endtask

    function automatic obs_t expect_of(input int k);
        obs_t e;
        e.pc      = 12'(m_pc[k]);
        e.running = (m_phase[k] == 1) || (m_phase[k] == 2);
        e.done    = (m_phase[k] == 3);
        e.fault   = m_fault[k];
        e.cnt     = 16'(m_cnt[k]);
        return e;
    endfunction

    task automatic push_expect();
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    endtask

    // One clock: model sees the same inputs the DUT samples at the edge.
    task automatic step();
        @(posedge Clk);
        model_step(0);
        model_step(1);
        push_expect();
        @(negedge Clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic sl, input logic br,
                         input logic [D-1:0] tg, input logic ht);
        Start = st; Stall = sl; BranchEn = br; Target = tg; Halt = ht;
    endtask

    // Reset raised between edges; the following falling-edge check must
    // already see the cleared state.
    task automatic async_reset();
        @(posedge Clk);
        model_step(0);
        model_step(1);
        #2;
        Reset = 1'b1;
        model_reset(0);
        model_reset(1);
        push_expect();
        @(negedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    always @(negedge Clk) begin
        obs_t a;
        obs_t e;
        cyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {pa0, run0, done0, flt0, cnt0};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL dut0 cyc %0d: got pc=%h run=%b done=%b fault=%b cnt=%0d want pc=%h run=%b done=%b fault=%b cnt=%0d",
                         cyc, a.pc, a.running, a.done, a.fault, a.cnt,
                         e.pc, e.running, e.done, e.fault, e.cnt);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {pa1, run1, done1, flt1, {13'd0, cnt1}};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL dut_hi cyc %0d: got pc=%h run=%b done=%b fault=%b cnt=%0d want pc=%h run=%b done=%b fault=%b cnt=%0d",
                         cyc, a.pc, a.running, a.done, a.fault, a.cnt,
                         e.pc, e.running, e.done, e.fault, e.cnt);
            end
        end
    end

    initial begin
        Reset = 1'b1;
        drive(0, 0, 0, '0, 0);
        model_reset(0);
        model_reset(1);
        step();
        step();
        Reset = 1'b0;
        step();

        // Plain run then halt: 0..5, drain, done, count 6.
        drive(1, 0, 0, '0, 0); step();
        drive(0, 0, 0, '0, 0);
        for (int i = 0; i < 5; i++) step();
        drive(0, 0, 0, '0, 1); step();
        drive(0, 0, 0, '0, 0); step(); step();
        $display("directed: plain run + halt done");

        // Branches: 0->10, -5 ->5, +20 ->25, -25 ->0, -1 ->0xFFF, then fault.
        drive(1, 0, 0, '0, 0); step();
        drive(0, 0, 1, 12'h00A, 0); step();
        drive(0, 0, 1, 12'hFFB, 0); step();
        drive(0, 0, 1, 12'h014, 0); step();
        drive(0, 0, 1, 12'hFE7, 0); step();
        drive(0, 0, 1, 12'hFFF, 0); step();
        drive(0, 0, 0, '0, 0); step(); step();
        $display("directed: branch offsets + wrap + fault done");

        // Stall with branch+halt pending, then halt on release.
        drive(1, 0, 0, '0, 0); step();
        drive(0, 0, 1, 12'h007, 0); step();
        drive(0, 1, 1, 12'h003, 1);
        for (int i = 0; i < 3; i++) step();
        drive(0, 0, 1, 12'h003, 1); step();
        drive(0, 1, 0, '0, 0); step(); step();
        $display("directed: stall priority done");

        // Zero-offset branches retire without moving: saturates dut_hi count.
        drive(1, 0, 0, '0, 0); step();
        drive(0, 0, 1, 12'h000, 0);
        for (int i = 0; i < 10; i++) step();
        drive(0, 0, 0, '0, 1); step();
        drive(0, 0, 0, '0, 0); step(); step();
        $display("directed: counter saturation done");

        // Restart from DONE; Start held through the run; async reset at 0x123.
        drive(1, 0, 0, '0, 0); step();
        step(); step();
        drive(1, 0, 1, 12'h123, 0); step();
        async_reset();
        drive(0, 0, 0, '0, 0); step();
        drive(1, 0, 0, '0, 0); step();
        drive(0, 0, 0, '0, 0); step(); step();
        $display("directed: restart + async reset done");

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0), 12'($urandom_range(0, 4095)),
                  ($urandom_range(0, 19) == 0));
            Reset = ($urandom_range(0, 99) == 0);
            step();
            Reset = 1'b0;
        end
        drive(0, 0, 0, '0, 0);
        step();
        $display("random: 400 cycles done");

        @(negedge Clk);
        #1;
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d queued want 0/0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
